// File: rtl/jtdsp16_ram_agu.sv
// RAM address generator: NPTR post-modified pointers plus j/k strides and an
// rb..re circular window, issuing one registered address per request.
module jtdsp16_ram_agu #(
  parameter  int AW    = 16,
  parameter  int NPTR  = 4,
  parameter  int NCIRC = 4,
  localparam int SELW  = $clog2(NPTR + 4),
  localparam int PW    = (NPTR > 1) ? $clog2(NPTR) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            ld_en,
  input  logic [SELW-1:0] ld_sel,
  input  logic [AW-1:0]   ld_data,
  input  logic [SELW-1:0] rd_sel,
  output logic [AW-1:0]   rd_data,
  input  logic            req,
  input  logic [PW-1:0]   ptr_sel,
  input  logic [2:0]      post,
  output logic [AW-1:0]   addr,
  output logic            addr_vld,
  output logic            wrap
);

  logic [AW-1:0] r_reg  [NPTR];
  logic [AW-1:0] r_next [NPTR];
  logic [AW-1:0] j_reg, k_reg, rb_reg, re_reg;
  logic [AW-1:0] j_next, k_next, rb_next, re_next;
  logic [AW-1:0] addr_reg, rd_data_reg, rd_next;
  logic          addr_vld_reg, wrap_reg;

  logic [AW-1:0] cur_ptr, mod_val;
  logic          issue, circ_ok, do_wrap;
  logic [NPTR-1:0] ld_hit, iss_hit;

  always_comb begin
    cur_ptr = '0;
    for (int i = 0; i < NPTR; i++)
      if (ptr_sel == PW'(i)) cur_ptr = r_reg[i];
  end

  // Unused pointer codes are treated exactly like an idle cycle.
  assign issue   = req && (32'(ptr_sel) < 32'(NPTR));
  assign circ_ok = 32'(ptr_sel) < 32'(NCIRC);
  assign do_wrap = issue && (re_reg != '0) && circ_ok &&
                   (post == 3'd1) && (cur_ptr == re_reg);

  always_comb begin
    case (post)
      3'd1:    mod_val = cur_ptr + AW'(1);
      3'd2:    mod_val = cur_ptr - AW'(1);
      3'd3:    mod_val = cur_ptr + j_reg;
      3'd4:    mod_val = cur_ptr + k_reg;
      default: mod_val = cur_ptr;
    endcase
    if (do_wrap) mod_val = rb_reg;
  end

  // A load on the same pointer overrides its post-modification.
  generate
    for (genvar gi = 0; gi < NPTR; gi++) begin : g_ptr
      assign ld_hit[gi]  = ld_en && (ld_sel == SELW'(gi));
      assign iss_hit[gi] = issue && (ptr_sel == PW'(gi));
      assign r_next[gi]  = ld_hit[gi]  ? ld_data :
                           iss_hit[gi] ? mod_val : r_reg[gi];
    end
  endgenerate

  assign j_next  = (ld_en && ld_sel == SELW'(NPTR))     ? ld_data : j_reg;
  assign k_next  = (ld_en && ld_sel == SELW'(NPTR + 1)) ? ld_data : k_reg;
  assign rb_next = (ld_en && ld_sel == SELW'(NPTR + 2)) ? ld_data : rb_reg;
  assign re_next = (ld_en && ld_sel == SELW'(NPTR + 3)) ? ld_data : re_reg;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NPTR; i++)
      if (rd_sel == SELW'(i)) rd_next = r_reg[i];
    if (rd_sel == SELW'(NPTR))     rd_next = j_reg;
    if (rd_sel == SELW'(NPTR + 1)) rd_next = k_reg;
    if (rd_sel == SELW'(NPTR + 2)) rd_next = rb_reg;
    if (rd_sel == SELW'(NPTR + 3)) rd_next = re_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPTR; i++) r_reg[i] <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      rb_reg       <= '0;
      re_reg       <= '0;
      addr_reg     <= '0;
      addr_vld_reg <= 1'b0;
      wrap_reg     <= 1'b0;
      rd_data_reg  <= '0;
    end else if (cen) begin
      for (int i = 0; i < NPTR; i++) r_reg[i] <= r_next[i];
      j_reg        <= j_next;
      k_reg        <= k_next;
      rb_reg       <= rb_next;
      re_reg       <= re_next;
      if (issue) addr_reg <= cur_ptr;
      addr_vld_reg <= issue;
      wrap_reg     <= do_wrap;
      rd_data_reg  <= rd_next;
    end
  end

  assign addr     = addr_reg;
  assign addr_vld = addr_vld_reg;
  assign wrap     = wrap_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: doc/jtdsp16_ram_agu.md
Name: jtdsp16_ram_agu

Overview:
Parametrised RAM address generator, successor to the fixed 16-bit DSP16 RAM address arithmetic unit. It holds NPTR pointer registers plus the j, k, rb and re registers, and issues one registered RAM address per request. Each issue applies a post-modification to the selected pointer, with a virtual-shift-register (circular buffer) wrap from re back to rb. It sits between the instruction decoder and the data RAM, and is clocked through the shared cen enable.

Parameters:
AW, 16, address and register width in bits
NPTR, 4, number of pointer registers r0..r(NPTR-1), range 1..8
NCIRC, 4, pointers with index < NCIRC obey circular wrap; others never wrap
SELW (localparam), $clog2(NPTR+4), register-select width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cen  in  1  clock enable; no state changes when low
ld_en  in  1  register load strobe
ld_sel  in  SELW  0..NPTR-1 = rN; NPTR = j; NPTR+1 = k; NPTR+2 = rb; NPTR+3 = re
ld_data  in  AW  load value
rd_sel  in  SELW  register read-back select, same map as ld_sel
rd_data  out  AW  registered read-back value
req  in  1  address issue request
ptr_sel  in  $clog2(NPTR) (min 1)  pointer used by req
post  in  3  0 none, 1 +1, 2 -1, 3 +j, 4 +k, 5-7 treated as none
addr  out  AW  issued RAM address
addr_vld  out  1  addr valid pulse
wrap  out  1  pulse: this issue triggered a circular wrap

Behaviour:
- Reset (rst high at a clk edge, regardless of cen): all rN, j, k, rb and re go to 0; addr=0, addr_vld=0, wrap=0, rd_data=0. Reset mid-operation discards any in-flight request, so no addr_vld follows it.
- All updates occur only on clk edges with cen=1. With cen=0, every register holds, including addr_vld and wrap (pulses stretch until the next cen).
- Issue: on a cen edge with req=1, addr <= r[ptr_sel] (pre-modification value), addr_vld <= 1, and r[ptr_sel] <= next value. Latency is 1 cen cycle. On a cen edge with req=0, addr_vld <= 0, wrap <= 0, and addr holds.
- Next value is modulo 2^AW: +1, -1, +j or +k. j and k are two's complement, so negative strides wrap naturally.
- Circular wrap: applies when re != 0, ptr_sel < NCIRC, post=1 and r[ptr_sel]==re. The next value is then rb instead of re+1, and wrap <= 1. No wrap occurs for -1, +j, +k or none, even when the pointer equals re. re=0 disables circular mode entirely.
- rb > re is legal. Wrap is an equality test only; a pointer stepped past re never wraps.
- Load: on a cen edge with ld_en=1, the selected register <= ld_data. ld_sel values beyond NPTR+3 are ignored.
- Load/issue collision on the same pointer in the same cycle: the load wins for the pointer's new value. addr still outputs the old pointer value.
- A load of j, k, rb or re takes effect for issues in the following cycle. A same-cycle issue uses the pre-load values.
- Read-back: rd_data <= selected register every cen edge (1-cycle latency). It reflects register values before that edge's updates. Out-of-range rd_sel returns 0.
- Unused ptr_sel codes (ptr_sel >= NPTR) behave as req=0: no addr_vld and no state change.

Test Plan:
- Reset then read all registers -> every rd_data = 0; addr_vld=0; wrap=0.
- AW=16: load r0=0x0010, issue r0 with post=1 three times -> addr 0x0010, 0x0011, 0x0012 on consecutive cycles; r0 ends at 0x0013.
- Load rb=0x0100, re=0x0103, r1=0x0102; issue r1 with post=1 ×3 -> addr 0x0102, 0x0103 (wrap=1), 0x0100; r1=0x0101. Repeat with re=0 -> no wrap, r1 reaches 0x0105.
- Load j=0xFFFE (-2), r2=0x0001; issue r2 with post=3 -> addr 0x0001, r2=0xFFFF. Then post=2 -> addr 0xFFFF, r2=0xFFFE (modular).
- Same cycle: ld_en with ld_sel=r3, ld_data=0x0500, and req on r3 with post=1 from r3=0x0020 -> addr=0x0020, r3=0x0500.
- Toggle cen low for 3 cycles during a request burst -> addr, addr_vld and pointers frozen, then resume identically. Assert rst mid-burst -> all zero and no pending addr_vld; repeat at NPTR=8, AW=12, NCIRC=2 (r5 at re never wraps).
